// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared constants, FSM encoding and index helpers for the skew feeder
package matmul_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DIM        = 4;
  localparam int BUS_WIDTH  = DIM * DIM * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Skewed injection needs N cycles of data plus 2(N-1) cycles of diagonal offset
  function automatic int feed_len(input int n);
    return 3 * n - 2;
  endfunction

  localparam int FEED_LEN = feed_len(DIM);

  function automatic int elem_lsb(input int row, input int col, input int n, input int dw);
    return (row * n + col) * dw;
  endfunction

endpackage

// File: rtl/matmul_skew_feeder_if.sv
// rtl/matmul_skew_feeder_if.sv - operand/control bundle between job source, feeder and collector
interface matmul_skew_feeder_if #(
  parameter int DATA_WIDTH = matmul_pkg::DATA_WIDTH,
  parameter int DIM        = matmul_pkg::DIM
);

  logic                            go_i;
  logic                            mode_i;
  logic [DIM*DIM*DATA_WIDTH-1:0]   a_mat_i;
  logic [DIM*DIM*DATA_WIDTH-1:0]   b_mat_i;
  logic                            res_ack_i;
  logic                            busy_o;
  logic [DIM*DATA_WIDTH-1:0]       a_row_o;
  logic [DIM*DATA_WIDTH-1:0]       b_col_o;
  logic                            start_o;
  logic                            mode_bit_o;
  logic                            done_o;

  modport master (
    output go_i, mode_i, a_mat_i, b_mat_i, res_ack_i,
    input  busy_o, a_row_o, b_col_o, start_o, mode_bit_o, done_o
  );

  modport slave (
    input  go_i, mode_i, a_mat_i, b_mat_i, res_ack_i,
    output busy_o, a_row_o, b_col_o, start_o, mode_bit_o, done_o
  );

endinterface

// File: rtl/matmul_skew_feeder_lane.sv
// rtl/matmul_skew_feeder_lane.sv - picks element (t - LANE) of an N-element vector, 0 when out of range
module feeder_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4,
  parameter int LANE       = 0,
  parameter int T_W        = 4
) (
  input  logic [DIM*DATA_WIDTH-1:0] vec_i,
  input  logic [T_W-1:0]            t_i,
  output logic [DATA_WIDTH-1:0]     elem_o
);

  // Compare against t = LANE + k instead of subtracting, so no negative index ever forms
  always_comb begin
    elem_o = '0;
    for (int k = 0; k < DIM; k++) begin
      if (t_i == T_W'(LANE + k)) begin
        elem_o = vec_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/matmul_skew_feeder.sv
// rtl/matmul_skew_feeder.sv - latches A/B, injects them skewed into the PE array edges, runs start/done/ack
module matmul_skew_feeder #(
  parameter int DATA_WIDTH = matmul_pkg::DATA_WIDTH,
  parameter int DIM        = matmul_pkg::DIM
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  matmul_skew_feeder_if.slave bus
);

  import matmul_pkg::*;

  localparam int FLEN   = feed_len(DIM);
  localparam int TW     = $clog2(3 * DIM);
  localparam int LANE_W = DIM * DATA_WIDTH;
  localparam int MAT_W  = DIM * LANE_W;

  state_e                     state_q, state_d;
  logic [TW-1:0]              t_q, t_d;
  logic [MAT_W-1:0]           a_lat_q, a_lat_d;
  logic [MAT_W-1:0]           b_lat_q, b_lat_d;
  logic                       mode_q, mode_d;
  logic                       busy_q, busy_d;
  logic                       start_q, start_d;
  logic                       mode_bit_q, mode_bit_d;
  logic                       done_q, done_d;
  logic [LANE_W-1:0]          a_row_q, a_row_d;
  logic [LANE_W-1:0]          b_col_q, b_col_d;
  logic [LANE_W-1:0]          a_sel, b_sel;
  logic [DIM-1:0][LANE_W-1:0] b_cols;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_lat_d = a_lat_q;
    b_lat_d = b_lat_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.go_i) begin
          state_d = ST_FEED;
          t_d     = '0;
          a_lat_d = bus.a_mat_i;
          b_lat_d = bus.b_mat_i;
          mode_d  = bus.mode_i;
        end
      end
      ST_FEED: begin
        if (t_q == TW'(FLEN - 1)) begin
          state_d = ST_HOLD;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.res_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A rows are contiguous in a_mat; B columns are strided and get gathered here
  always_comb begin
    b_cols = '0;
    for (int j = 0; j < DIM; j++) begin
      for (int k = 0; k < DIM; k++) begin
        b_cols[j][k*DATA_WIDTH +: DATA_WIDTH] =
          b_lat_d[elem_lsb(k, j, DIM, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    feeder_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .DIM       (DIM),
      .LANE      (g),
      .T_W       (TW)
    ) u_a_lane (
      .vec_i (a_lat_d[g*LANE_W +: LANE_W]),
      .t_i   (t_d),
      .elem_o(a_sel[g*DATA_WIDTH +: DATA_WIDTH])
    );

    feeder_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .DIM       (DIM),
      .LANE      (g),
      .T_W       (TW)
    ) u_b_lane (
      .vec_i (b_cols[g]),
      .t_i   (t_d),
      .elem_o(b_sel[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Outputs are computed from next-state so the registered values line up with t_q
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    start_d    = (state_d != ST_IDLE);
    mode_bit_d = (state_d != ST_IDLE) & mode_d;
    done_d     = (state_d == ST_HOLD);
    a_row_d    = (state_d == ST_FEED) ? a_sel : '0;
    b_col_d    = (state_d == ST_FEED) ? b_sel : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      t_q        <= '0;
      a_lat_q    <= '0;
      b_lat_q    <= '0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      mode_bit_q <= 1'b0;
      done_q     <= 1'b0;
      a_row_q    <= '0;
      b_col_q    <= '0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      a_lat_q    <= a_lat_d;
      b_lat_q    <= b_lat_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      mode_bit_q <= mode_bit_d;
      done_q     <= done_d;
      a_row_q    <= a_row_d;
      b_col_q    <= b_col_d;
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.start_o    = start_q;
  assign bus.mode_bit_o = mode_bit_q;
  assign bus.done_o     = done_q;
  assign bus.a_row_o    = a_row_q;
  assign bus.b_col_o    = b_col_q;

endmodule

// File: tb/tb_matmul_skew_feeder.sv
// tb/tb_matmul_skew_feeder.sv - scoreboard bench for the skew feeder with behavioural PE arrays (N=2, N=4)
module tb_matmul_skew_feeder;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        mode;
  } lane_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  matmul_skew_feeder_if #(.DATA_WIDTH(8), .DIM(2)) if2 ();
  matmul_skew_feeder_if #(.DATA_WIDTH(8), .DIM(4)) if4 ();

  matmul_skew_feeder #(.DATA_WIDTH(8), .DIM(2)) dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));
  matmul_skew_feeder #(.DATA_WIDTH(8), .DIM(4)) dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(if4));

  lane_t        lq2[$];
  lane_t        lq4[$];
  logic [511:0] rq2[$];
  logic [511:0] rq4[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Output-stationary PE arrays fed by the DUT edges
  logic signed [7:0] pa2 [2][2];
  logic signed [7:0] pb2 [2][2];
  int                acc2 [2][2];
  logic signed [7:0] pa4 [4][4];
  logic signed [7:0] pb4 [4][4];
  int                acc4 [4][4];

  function automatic logic signed [7:0] ain2(input int i, input int j);
    return (j == 0) ? $signed(if2.a_row_o[i*8 +: 8]) : pa2[i][(j > 0) ? j-1 : 0];
  endfunction
  function automatic logic signed [7:0] bin2(input int i, input int j);
    return (i == 0) ? $signed(if2.b_col_o[j*8 +: 8]) : pb2[(i > 0) ? i-1 : 0][j];
  endfunction
  function automatic logic signed [7:0] ain4(input int i, input int j);
    return (j == 0) ? $signed(if4.a_row_o[i*8 +: 8]) : pa4[i][(j > 0) ? j-1 : 0];
  endfunction
  function automatic logic signed [7:0] bin4(input int i, input int j);
    return (i == 0) ? $signed(if4.b_col_o[j*8 +: 8]) : pb4[(i > 0) ? i-1 : 0][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (if2.start_o !== 1'b1) begin
          acc2[i][j] <= 0; pa2[i][j] <= '0; pb2[i][j] <= '0;
        end else begin
          acc2[i][j] <= acc2[i][j] + int'(ain2(i, j)) * int'(bin2(i, j));
          pa2[i][j]  <= ain2(i, j);
          pb2[i][j]  <= bin2(i, j);
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (if4.start_o !== 1'b1) begin
          acc4[i][j] <= 0; pa4[i][j] <= '0; pb4[i][j] <= '0;
        end else begin
          acc4[i][j] <= acc4[i][j] + int'(ain4(i, j)) * int'(bin4(i, j));
          pa4[i][j]  <= ain4(i, j);
          pb4[i][j]  <= bin4(i, j);
        end
      end
    end
  end

  // Monitors: FEED cycles pop lane expectations, HOLD cycles compare the array result
  logic dprev2 = 1'b0;
  logic dprev4 = 1'b0;

  always @(negedge clk) begin
    if (if2.busy_o === 1'b1 && if2.done_o === 1'b0) begin
      if (lq2.size() == 0) chk("feed2_queue", 64'(lq2.size()), 1);
      else begin
        chk("feed2_a_row", 64'(if2.a_row_o), 64'(lq2[0].a[15:0]));
        chk("feed2_b_col", 64'(if2.b_col_o), 64'(lq2[0].b[15:0]));
        chk("feed2_mode", 64'(if2.mode_bit_o), 64'(lq2[0].mode));
        chk("feed2_start", 64'(if2.start_o), 1);
        lq2.delete(0);
      end
    end
    if (if2.done_o === 1'b1) begin
      if (rq2.size() == 0) chk("res2_queue", 64'(rq2.size()), 1);
      else begin
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++)
            chk($sformatf("res2_%0d%0d", i, j), 64'(acc2[i][j]),
                64'($signed(rq2[0][(i*2+j)*32 +: 32])));
        chk("hold2_start", 64'(if2.start_o), 1);
        chk("hold2_lanes", 64'({if2.a_row_o, if2.b_col_o}), 0);
      end
    end
    if (dprev2 && if2.done_o === 1'b0 && rq2.size() > 0) rq2.delete(0);
    dprev2 <= (if2.done_o === 1'b1);
  end

  always @(negedge clk) begin
    if (if4.busy_o === 1'b1 && if4.done_o === 1'b0) begin
      if (lq4.size() == 0) chk("feed4_queue", 64'(lq4.size()), 1);
      else begin
        chk("feed4_a_row", 64'(if4.a_row_o), 64'(lq4[0].a));
        chk("feed4_b_col", 64'(if4.b_col_o), 64'(lq4[0].b));
        chk("feed4_mode", 64'(if4.mode_bit_o), 64'(lq4[0].mode));
        lq4.delete(0);
      end
    end
    if (if4.done_o === 1'b1) begin
      if (rq4.size() == 0) chk("res4_queue", 64'(rq4.size()), 1);
      else begin
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            chk($sformatf("res4_%0d%0d", i, j), 64'(acc4[i][j]),
                64'($signed(rq4[0][(i*4+j)*32 +: 32])));
        chk("hold4_mode", 64'(if4.mode_bit_o), 1);
      end
    end
    if (dprev4 && if4.done_o === 1'b0 && rq4.size() > 0) rq4.delete(0);
    dprev4 <= (if4.done_o === 1'b1);
  end

  function automatic logic [31:0] skew(input int n, input logic [127:0] m, input int t, input bit is_b);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < n; l++) begin
      int k;
      k = t - l;
      if (k >= 0 && k < n)
        r[l*8 +: 8] = is_b ? m[(k*n+l)*8 +: 8] : m[(l*n+k)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [511:0] res2(input int r00, input int r01, input int r10, input int r11);
    logic [511:0] r;
    r = '0;
    r[0 +: 32] = r00; r[32 +: 32] = r01; r[64 +: 32] = r10; r[96 +: 32] = r11;
    return r;
  endfunction

  task automatic push_lanes(input int n, input logic [127:0] a, input logic [127:0] b, input logic m);
    for (int t = 0; t < 3*n-2; t++) begin
      if (n == 2) lq2.push_back('{skew(n, a, t, 0), skew(n, b, t, 1), m});
      else        lq4.push_back('{skew(n, a, t, 0), skew(n, b, t, 1), m});
    end
  endtask

  // Hand-derived lanes for A=[[1,2],[3,4]], B=[[5,6],[7,8]]
  task automatic push_job1(input int cnt);
    lane_t tbl [4];
    tbl[0] = '{32'h0001, 32'h0005, 1'b0};
    tbl[1] = '{32'h0302, 32'h0607, 1'b0};
    tbl[2] = '{32'h0400, 32'h0800, 1'b0};
    tbl[3] = '{32'h0000, 32'h0000, 1'b0};
    for (int t = 0; t < cnt; t++) lq2.push_back(tbl[t]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go2(input logic [31:0] a, input logic [31:0] b, input logic m);
    if2.a_mat_i = a; if2.b_mat_i = b; if2.mode_i = m; if2.go_i = 1'b1;
    step();
    if2.go_i = 1'b0;
  endtask

  task automatic wait_done(input int n, input int exp_cyc, input string nm);
    int cyc;
    cyc = 0;
    while (((n == 2) ? if2.done_o : if4.done_o) !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    chk(nm, 64'(cyc), 64'(exp_cyc));
  endtask

  task automatic finish_job(input int n, input string nm);
    if (n == 2) if2.res_ack_i = 1'b1; else if4.res_ack_i = 1'b1;
    step();
    if2.res_ack_i = 1'b0; if4.res_ack_i = 1'b0;
    if (n == 2) chk({nm, "_idle"}, 64'({if2.start_o, if2.busy_o, if2.done_o}), 0);
    else        chk({nm, "_idle"}, 64'({if4.start_o, if4.busy_o, if4.done_o}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] a4, b4;
    logic [511:0] r4;
    int           bv [16];

    if2.go_i = 1'b0; if2.mode_i = 1'b0; if2.a_mat_i = '0; if2.b_mat_i = '0; if2.res_ack_i = 1'b0;
    if4.go_i = 1'b0; if4.mode_i = 1'b0; if4.a_mat_i = '0; if4.b_mat_i = '0; if4.res_ack_i = 1'b0;
    repeat (3) step();
    chk("reset2_outs", 64'({if2.busy_o, if2.start_o, if2.mode_bit_o, if2.done_o, if2.a_row_o, if2.b_col_o}), 0);
    chk("reset4_outs", 64'({if4.busy_o, if4.start_o, if4.mode_bit_o, if4.done_o, if4.a_row_o, if4.b_col_o}), 0);
    rst_n = 1'b1;
    step();

    // Basic 2x2 job, then a 10-cycle hold before ack
    push_job1(4);
    rq2.push_back(res2(19, 22, 43, 50));
    go2(32'h04030201, 32'h08070605, 1'b0);
    wait_done(2, 4, "t1_latency");
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t2_hold", 64'({if2.start_o, if2.done_o, if2.busy_o}), 64'(3'b111));
    end
    finish_job(2, "t2_ack");
    step();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        chk("t2_cleared", 64'(acc2[i][j]), 0);

    // go_i with a different A in FEED must be ignored
    push_job1(4);
    rq2.push_back(res2(19, 22, 43, 50));
    go2(32'h04030201, 32'h08070605, 1'b0);
    step();
    step();
    if2.a_mat_i = 32'h11111111; if2.go_i = 1'b1;
    step();
    if2.go_i = 1'b0;
    wait_done(2, 1, "t3_latency");
    finish_job(2, "t3_ack");

    // Reset at FEED t=2, then a fresh signed job
    push_job1(3);
    go2(32'h04030201, 32'h08070605, 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("t4_rst_outs", 64'({if2.busy_o, if2.start_o, if2.mode_bit_o, if2.done_o, if2.a_row_o, if2.b_col_o}), 0);
    chk("t4_rst_queue", 64'(lq2.size()), 0);
    rst_n = 1'b1;
    step();
    push_lanes(2, 128'hFC0302FF, 128'h0807FA05, 1'b0);
    rq2.push_back(res2(9, 22, -13, -50));
    go2(32'hFC0302FF, 32'h0807FA05, 1'b0);
    wait_done(2, 4, "t4_latency");
    finish_job(2, "t4_ack");

    // Back-to-back: go in the single IDLE cycle after ack
    push_job1(4);
    rq2.push_back(res2(19, 22, 43, 50));
    go2(32'h04030201, 32'h08070605, 1'b0);
    chk("t6_refeed_start", 64'(if2.start_o), 1);
    wait_done(2, 4, "t6_latency");
    finish_job(2, "t6_ack");

    // 4x4 identity times signed B in accumulate mode
    bv = '{-128, 127, 3, -4, 5, -6, 7, -8, 9, 10, -11, 12, 127, -128, 0, 1};
    a4 = '0; b4 = '0; r4 = '0;
    for (int i = 0; i < 4; i++) a4[(i*4+i)*8 +: 8] = 8'd1;
    for (int i = 0; i < 16; i++) begin
      b4[i*8 +: 8]  = bv[i][7:0];
      r4[i*32 +: 32] = bv[i];
    end
    push_lanes(4, a4, b4, 1'b1);
    rq4.push_back(r4);
    if4.a_mat_i = a4; if4.b_mat_i = b4; if4.mode_i = 1'b1; if4.go_i = 1'b1;
    step();
    if4.go_i = 1'b0; if4.mode_i = 1'b0;
    wait_done(4, 10, "t5_latency");
    step();
    finish_job(4, "t5_ack");

    step();
    step();
    chk("end_queues", 64'(lq2.size() + lq4.size() + rq2.size() + rq4.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
